// File: rtl/multibyte_add_sequencer.sv
// -----------------------------------------------------------------------------
// multibyte_add_sequencer
//
// Performs one unsigned add of 8*NBYTES bits by stepping an external clocked
// 8-bit byte adder through the operand bytes, least-significant byte first.
// Each byte step holds its operands for ADDER_LAT+1 cycles. At the last edge of
// the step the byte sum is captured into the wide result, and the carry-out is
// forwarded as the carry-in of the next byte.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start_valid/ready       request handshake (ready only while idle)
//   op_a, op_b, op_cin      wide operands and carry into byte 0
//   add_a, add_b, add_cin   byte operands driven to the byte adder
//   add_sum, add_cout       byte adder result
//   res_valid/ready         result handshake
//   res_sum, res_cout       assembled sum (mod 2^(8*NBYTES)) and final carry
//
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module multibyte_add_sequencer #(
  parameter int NBYTES    = 4,
  parameter int ADDER_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                op_cin,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] res_sum,
  output logic                res_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(ADDER_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state, w_state;
  logic [W-1:0]    r_a, w_a;
  logic [W-1:0]    r_b, w_b;
  logic [KW-1:0]   r_k, w_k;
  logic [SW-1:0]   r_step, w_step;
  logic [7:0]      r_add_a, w_add_a;
  logic [7:0]      r_add_b, w_add_b;
  logic            r_add_cin, w_add_cin;
  logic [W-1:0]    r_res_sum, w_res_sum;
  logic            r_res_cout, w_res_cout;
  logic            r_res_valid, w_res_valid;
  logic            r_start_ready, w_start_ready;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    w_state    = r_state;
    w_a        = r_a;
    w_b        = r_b;
    w_k        = r_k;
    w_step     = r_step;
    w_add_a    = r_add_a;
    w_add_b    = r_add_b;
    w_add_cin  = r_add_cin;
    w_res_sum  = r_res_sum;
    w_res_cout = r_res_cout;

    unique case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_state   = S_RUN;
          w_a       = op_a;
          w_b       = op_b;
          w_k       = '0;
          w_step    = '0;
          w_add_a   = op_a[7:0];
          w_add_b   = op_b[7:0];
          w_add_cin = op_cin;
        end
      end

      S_RUN: begin
        if (r_step != S_LAST) begin
          w_step = r_step + 1'b1;
        end else begin
          // Last edge of this byte step: the adder result is valid now.
          w_step = '0;
          w_res_sum[8*r_k +: 8] = add_sum;
          if (r_k != K_LAST) begin
            w_k       = r_k + 1'b1;
            w_add_a   = r_a[8*w_k +: 8];
            w_add_b   = r_b[8*w_k +: 8];
            w_add_cin = add_cout;
          end else begin
            w_k        = '0;
            w_res_cout = add_cout;
            w_state    = S_DONE;
            w_add_a    = '0;
            w_add_b    = '0;
            w_add_cin  = 1'b0;
          end
        end
      end

      S_DONE: begin
        if (res_ready) w_state = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase

    // Handshake flags are registered decodes of the next state.
    w_start_ready = (w_state == S_IDLE);
    w_res_valid   = (w_state == S_DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand latches are plain data registers but are reset anyway,
    // so an abandoned operation leaves nothing behind for the next request.
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_k           <= '0;
      r_step        <= '0;
      r_add_a       <= '0;
      r_add_b       <= '0;
      r_add_cin     <= 1'b0;
      r_res_sum     <= '0;
      r_res_cout    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      r_state       <= w_state;
      r_a           <= w_a;
      r_b           <= w_b;
      r_k           <= w_k;
      r_step        <= w_step;
      r_add_a       <= w_add_a;
      r_add_b       <= w_add_b;
      r_add_cin     <= w_add_cin;
      r_res_sum     <= w_res_sum;
      r_res_cout    <= w_res_cout;
      r_res_valid   <= w_res_valid;
      r_start_ready <= w_start_ready;
    end
  end

  assign start_ready = r_start_ready;
  assign add_a       = r_add_a;
  assign add_b       = r_add_b;
  assign add_cin     = r_add_cin;
  assign res_valid   = r_res_valid;
  assign res_sum     = r_res_sum;
  assign res_cout    = r_res_cout;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multibyte_add_sequencer
//
// Drives multibyte_add_sequencer (NBYTES=4, ADDER_LAT=1) against a registered
// 8-bit byte adder model. Results are compared with a plain wide-arithmetic
// reference. Stimulus is driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_multibyte_add_sequencer;

  localparam int NB  = 4;
  localparam int LAT = 1;
  localparam int W   = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
  logic [7:0]   add_a, add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;
  logic         res_cout;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the most recent operation.
  logic [7:0] obs_a   [NB];
  logic [7:0] obs_b   [NB];
  logic       obs_cin [NB];
  int         obs_lat;
  bit         obs_done;

  always #5 clk = ~clk;

  multibyte_add_sequencer #(.NBYTES(NB), .ADDER_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_cout    (res_cout)
  );

  // Registered byte adder: one edge from sampling to valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {add_cout, add_sum} <= '0;
    else        {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);
  end

  // ---------------------------------------------------------------- reference
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  // Carry into byte k: carry out of the sum of the k low bytes plus cin.
  function automatic logic ref_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input int k);
    longint unsigned m, s;
    if (k == 0) return cin;
    m = (64'd1 << (8 * k)) - 64'd1;
    s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
    return s[8*k];
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] v, input int k);
    return v[8*k +: 8];
  endfunction

  // ---------------------------------------------------------------- drivers
  // Issues one request from a falling edge and waits for res_valid. obs_lat is
  // the number of rising edges after the accept edge at which res_valid is 1.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n;
    n = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    op_a = a; op_b = b; op_cin = cin; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    obs_done = 1'b0;
    obs_lat  = 0;
    for (int c = 0; c < 100; c++) begin
      if (res_valid) begin
        obs_lat  = c;
        obs_done = 1'b1;
        break;
      end
      if ((c % (LAT + 1)) == 0 && (c / (LAT + 1)) < NB) begin
        obs_a[c/(LAT+1)]   = add_a;
        obs_b[c/(LAT+1)]   = add_b;
        obs_cin[c/(LAT+1)] = add_cin;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!obs_done) begin
      n_fail++;
      $display("FAIL op_timeout: res_valid got 0 required 1 within 100 cycles (a=%h b=%h)", a, b);
    end
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({start_ready, res_valid, res_cout, add_cin, add_a, add_b, res_sum} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b vld=%b cout=%b cin=%b a=%h b=%h sum=%h required 1 0 0 0 00 00 00000000",
               start_ready, res_valid, res_cout, add_cin, add_a, add_b, res_sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry_ripple();
    logic [NB-1:0] exp_cin;
    bit bad;
    exp_cin = 4'b1110;   // bit k = carry into byte k
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    n_tests++;
    if (res_sum !== 32'h0 || res_cout !== 1'b1) begin
      n_fail++;
      $display("FAIL ripple_result: got %h/%b required 00000000/1", res_sum, res_cout);
    end
    n_tests++;
    if (obs_lat !== 8) begin
      n_fail++;
      $display("FAIL ripple_latency: got %0d required 8", obs_lat);
    end
    bad = 1'b0;
    for (int k = 0; k < NB; k++) if (obs_cin[k] !== exp_cin[k]) bad = 1'b1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL ripple_add_cin: got %b%b%b%b (byte0..3) required 0111",
               obs_cin[0], obs_cin[1], obs_cin[2], obs_cin[3]);
    end
    release_res();
  endtask

  task automatic test_no_carry();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    logic [W-1:0] ts [2];
    ta[0] = 32'h1234_5678; tb[0] = 32'h1111_1111; ts[0] = 32'h2345_6789;
    ta[1] = 32'h5555_5555; tb[1] = 32'hAAAA_AAAA; ts[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      do_op(ta[i], tb[i], 1'b0);
      n_tests++;
      if (res_sum !== ts[i] || res_cout !== 1'b0) begin
        n_fail++;
        $display("FAIL no_carry_%0d: got %h/%b required %h/0", i, res_sum, res_cout, ts[i]);
      end
      release_res();
    end
  endtask

  task automatic test_max_cin();
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    n_tests++;
    if (res_sum !== 32'hFFFF_FFFF || res_cout !== 1'b1) begin
      n_fail++;
      $display("FAIL max_cin: got %h/%b required ffffffff/1", res_sum, res_cout);
    end
    release_res();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         cin;
    logic [W:0]   exp;
    bit           bad;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      exp = ref_add(a, b, cin);
      do_op(a, b, cin);
      n_tests++;
      if ({res_cout, res_sum} !== exp) begin
        n_fail++;
        $display("FAIL random_result_%0d: %h+%h+%b got %b/%h required %b/%h",
                 i, a, b, cin, res_cout, res_sum, exp[W], exp[W-1:0]);
      end
      bad = 1'b0;
      for (int k = 0; k < NB; k++)
        if (obs_a[k] !== byte_of(a, k) || obs_b[k] !== byte_of(b, k) ||
            obs_cin[k] !== ref_cin(a, b, cin, k)) bad = 1'b1;
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL random_bytes_%0d: a=%h b=%h cin=%b got bytes a %h%h%h%h b %h%h%h%h cin %b%b%b%b (byte3..0)",
                 i, a, b, cin, obs_a[3], obs_a[2], obs_a[1], obs_a[0],
                 obs_b[3], obs_b[2], obs_b[1], obs_b[0],
                 obs_cin[3], obs_cin[2], obs_cin[1], obs_cin[0]);
      end
      release_res();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    logic [W:0]   exp;
    bit           bad;
    a   = $urandom;
    b   = $urandom;
    exp = ref_add(a, b, 1'b0);
    do_op(a, b, 1'b0);
    // New request offered while the result is held.
    op_a = ~a; op_b = ~b; op_cin = 1'b1; start_valid = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || {res_cout, res_sum} !== exp || start_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL backpressure_hold: vld=%b rdy=%b got %b/%h required vld=1 rdy=0 %b/%h",
               res_valid, start_ready, res_cout, res_sum, exp[W], exp[W-1:0]);
    end
    start_valid = 1'b0;
    release_res();
    n_tests++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || {res_cout, res_sum} !== exp) begin
      n_fail++;
      $display("FAIL backpressure_release: rdy=%b vld=%b %b/%h required rdy=1 vld=0 %b/%h",
               start_ready, res_valid, res_cout, res_sum, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_op();
    bit saw_valid;
    saw_valid = 1'b0;
    op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0001; op_cin = 1'b0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    // Five edges past accept: byte 2 is on the adder inputs.
    repeat (5) begin
      @(negedge clk);
      if (res_valid) saw_valid = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({start_ready, res_valid, res_cout, add_cin, add_a, add_b, res_sum} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0}) begin
      n_fail++;
      $display("FAIL midop_reset_values: rdy=%b vld=%b cout=%b cin=%b a=%h b=%h sum=%h required 1 0 0 0 00 00 00000000",
               start_ready, res_valid, res_cout, add_cin, add_a, add_b, res_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) saw_valid = 1'b1;
    end
    n_tests++;
    if (saw_valid) begin
      n_fail++;
      $display("FAIL midop_no_valid: res_valid got 1 required 0 for abandoned op");
    end
    do_op(32'h0000_0001, 32'h0000_0001, 1'b0);
    n_tests++;
    if (res_sum !== 32'h2 || res_cout !== 1'b0 || obs_cin[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_next_op: got %h/%b cin0=%b required 00000002/0 cin0=0",
               res_sum, res_cout, obs_cin[0]);
    end
    release_res();
  endtask

  task automatic test_back_to_back();
    int         acc [4];
    logic [W:0] got [2];
    int         n_acc, n_res;
    n_acc = 0;
    n_res = 0;
    res_ready = 1'b1;
    op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0001; op_cin = 1'b0;
    start_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (n_acc == 1) begin
        op_a = 32'h0000_0001; op_b = 32'h0000_0002; op_cin = 1'b0;
      end
      if (res_valid && n_res < 2) begin
        got[n_res] = {res_cout, res_sum};
        n_res++;
        if (n_res == 2) begin
          start_valid = 1'b0;
          break;
        end
      end
      if (start_ready && start_valid && n_acc < 4) begin
        acc[n_acc] = c;
        n_acc++;
      end
      @(negedge clk);
    end
    start_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    n_tests++;
    if (n_res != 2 || n_acc < 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results %0d accepts required 2 and 2", n_res, n_acc);
    end else begin
      n_tests++;
      if (acc[1] - acc[0] != 10) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d cycles required 10", acc[1] - acc[0]);
      end
      n_tests++;
      if (got[0] !== {1'b1, 32'h0} || got[1] !== {1'b0, 32'h3}) begin
        n_fail++;
        $display("FAIL b2b_results: got %h and %h required 100000000 and 000000003",
                 got[0], got[1]);
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_carry_ripple();
    test_no_carry();
    test_max_cin();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
